// File: rtl/param_datapath_pkg.sv
// Shared types for the parameterised register datapath: opcodes, controller
// states and the register-select width helper.
package param_datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MVI = 3'b101,
    OP_MV  = 3'b110,
    OP_JMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LDA  = 2'b01,
    ST_EXE  = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  function automatic int sel_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/param_datapath_alu.sv
// Combinational ALU for the datapath: add/sub/and/or/xor with zero, carry
// (no-borrow for SUB) and negative flags.
module param_datapath_alu
  import param_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Borrow appears in the extra MSB of diff_s; carry for SUB is its inverse.
  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_s[WIDTH-1:0];
        c      = sum_s[WIDTH];
      end
      OP_SUB: begin
        result = diff_s[WIDTH-1:0];
        c      = ~diff_s[WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);
  assign n = result[WIDTH-1];

endmodule

// File: rtl/param_datapath.sv
// Register-file datapath: single-cycle MVI/MV/JMP, four-phase ALU commands
// (IDLE->LDA->EXE->WB) with registered flags and a one-cycle done pulse.
module param_datapath
  import param_datapath_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NREGS  = 8,
  parameter  int ADDR_W = 9,
  localparam int SEL_W  = sel_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_rx,
  input  logic [SEL_W-1:0]  cmd_ry,
  input  logic [WIDTH-1:0]  cmd_imm,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic [WIDTH-1:0]  jmpaddr,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  bus
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  op_e                cmd_op_s;
  logic [SEL_W-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic [WIDTH-1:0]   a_q, a_d, g_q, g_d, jmp_q, jmp_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   regs_q [NREGS];

  logic               we_s;
  logic [SEL_W-1:0]   waddr_s;
  logic [WIDTH-1:0]   wdata_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_z_s, alu_c_s, alu_n_s;

  assign cmd_op_s = op_e'(cmd_op);

  param_datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (regs_q[ry_q]),
    .op     (op_q),
    .result (alu_res_s),
    .z      (alu_z_s),
    .c      (alu_c_s),
    .n      (alu_n_s)
  );

  // Controller next state, register-file write port and datapath updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    a_d     = a_q;
    g_d     = g_q;
    jmp_d   = jmp_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    done_d  = 1'b0;
    we_s    = 1'b0;
    waddr_s = rx_q;
    wdata_s = g_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op_s)
            OP_MVI: begin
              we_s    = 1'b1;
              waddr_s = cmd_rx;
              wdata_s = cmd_imm;
              done_d  = 1'b1;
            end
            OP_MV: begin
              we_s    = 1'b1;
              waddr_s = cmd_rx;
              wdata_s = regs_q[cmd_ry];
              done_d  = 1'b1;
            end
            OP_JMP: begin
              jmp_d  = WIDTH'(cmd_addr);
              done_d = 1'b1;
            end
            default: begin
              op_d    = cmd_op_s;
              rx_d    = cmd_rx;
              ry_d    = cmd_ry;
              state_d = ST_LDA;
            end
          endcase
        end
      end
      ST_LDA: begin
        a_d     = regs_q[rx_q];
        state_d = ST_EXE;
      end
      ST_EXE: begin
        g_d     = alu_res_s;
        z_d     = alu_z_s;
        c_d     = alu_c_s;
        n_d     = alu_n_s;
        state_d = ST_WB;
      end
      ST_WB: begin
        we_s    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      rx_q    <= '0;
      ry_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      jmp_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      a_q     <= a_d;
      g_q     <= g_d;
      jmp_q   <= jmp_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  // Register file: one write port, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_s) begin
      regs_q[waddr_s] <= wdata_s;
    end
  end

  // Bus shows whatever value the current phase is moving.
  always_comb begin
    bus = '0;
    case (state_q)
      ST_IDLE: bus = (cmd_op_s == OP_MVI) ? cmd_imm : '0;
      ST_LDA:  bus = regs_q[rx_q];
      ST_EXE:  bus = regs_q[ry_q];
      ST_WB:   bus = g_q;
      default: bus = '0;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign jmpaddr   = jmp_q;
  assign rd_data   = regs_q[rd_sel];

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter WIDTH, default 16: width of the data path and of all registers.
REQ-002 Parameter NREGS, default 8: number of general registers; power of two, at least 2; SEL_W = clog2(NREGS).
REQ-003 Parameter ADDR_W, default 9: width of the jump address; must not exceed WIDTH.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  block accepts a command; equals (state==IDLE).
REQ-008 cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MVI, 110 MV, 111 JMP.
REQ-009 cmd_rx  in  SEL_W  destination and first-operand register.
REQ-010 cmd_ry  in  SEL_W  second-operand register.
REQ-011 cmd_imm  in  WIDTH  immediate value for MVI.
REQ-012 cmd_addr  in  ADDR_W  target address for JMP.
REQ-013 done  out  1  one-cycle pulse on completion of each command.
REQ-014 flag_z, flag_c, flag_n  out  1 each  registered zero, carry and negative flags.
REQ-015 jmpaddr  out  WIDTH  jump register, zero-extended from ADDR_W.
REQ-016 rd_sel  in  SEL_W  debug read select; rd_data  out  WIDTH  equals R[rd_sel], combinational.
REQ-017 bus  out  WIDTH  internal bus value for the current cycle, combinational mux with no tri-states.

Function
REQ-018 A command is accepted on a rising edge when cmd_valid and cmd_ready are both 1; cmd_valid while busy is ignored and no command is queued.
REQ-019 ALU ops (000-100) use FSM IDLE->LDA->EXE->WB->IDLE, one edge per transition.
- LDA: A <= R[rx].
- EXE: G <= A op R[ry]; flags updated.
- WB: R[rx] <= G.
REQ-020 An ALU command accepted at edge e0 writes R[rx] at edge e3, and done is high for the cycle after e3.
REQ-021 MVI (R[rx] <= imm), MV (R[rx] <= R[ry]) and JMP (jmpaddr <= cmd_addr) complete at the accept edge; the FSM stays IDLE, done is high for the next cycle and a new command is accepted in that same cycle.
REQ-022 bus shows: IDLE -> cmd_imm for MVI, else 0; LDA -> R[rx]; EXE -> R[ry]; WB -> G.
REQ-023 Arithmetic wraps modulo 2^WIDTH.
- ADD: flag_c = carry out of bit WIDTH-1.
- SUB: flag_c = 1 when no borrow (A >= R[ry] unsigned).
- Logic ops: flag_c = 0.
REQ-024 flag_z = (result==0) and flag_n = result[WIDTH-1]; flags change only in EXE of ALU ops. MVI, MV and JMP leave the flags unchanged.
REQ-025 When rx==ry, the second operand is R[ry] as it stands at EXE, which is the pre-writeback value.
REQ-026 During an ALU op, rd_data reflects the registers as they are; there is no bypass.

Reset
REQ-027 rst=1 forces, without waiting for a clock edge:
- state IDLE;
- all R[i], A, G and jmpaddr to 0;
- flags 0;
- done 0.
REQ-028 A reset mid-operation abandons the command with no writeback and no done; cmd_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package param_datapath_pkg holds the opcode enum, the FSM state enum and the function computing SEL_W.
REQ-030 Sub-module param_datapath_alu, combinational, parameterised by WIDTH: inputs a, b and op; outputs result, z, c and n.
REQ-031 The register file is an array of NREGS x WIDTH flops with one write port and three read ports: operand, ry and rd_sel.

Verification
REQ-032 Reset, then MVI R1=0x0005, MVI R2=0x0003, ADD R1,R2 -> R1=0x0008 with done 3 cycles after ADD acceptance; Z=0, C=0, N=0.
REQ-033 MVI R3=0xFFFF, MVI R4=0x0001, ADD R3,R4 -> R3=0x0000, Z=1, C=1; then SUB R4,R4 -> R4=0, Z=1, C=1.
REQ-034 SUB with R0=0x0002 and R5=0x0003 -> R0=0xFFFF, N=1, C=0.
REQ-035 JMP addr=0x1FF -> jmpaddr=0x01FF; flags unchanged; done next cycle. Hold cmd_valid during an ADD -> cmd_ready=0 for 3 cycles and the second command is accepted only after that.
REQ-036 Assert rst during EXE of XOR R6,R7 -> all registers 0, no done; an MVI issued right after deassertion completes normally.
REQ-037 NREGS=16, WIDTH=32 build: MVI R15=0x80000000, ADD R15,R15 -> R15=0, C=1, Z=1.
